// File: rtl/hpi_pkg.sv
// Shared types for the CY7C67200 HPI transaction sequencer.
// Register selects, FSM states and the address auto-increment step.
package hpi_pkg;

  typedef enum logic [1:0] {
    HPI_DATA    = 2'b00,
    HPI_MAILBOX = 2'b01,
    HPI_ADDRESS = 2'b10,
    HPI_STATUS  = 2'b11
  } hpi_reg_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    A_STB = 3'd1,
    A_REC = 3'd2,
    D_STB = 3'd3,
    D_REC = 3'd4,
    DONE  = 3'd5
  } seq_state_e;

  localparam logic [15:0] HPI_ADDR_STEP = 16'd2;

  function automatic int max2(int a, int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hpi_rr_arb.sv
// Round-robin arbiter: priority starts one past the last grantee.
// Grant is one-hot and purely combinational.
module hpi_rr_arb
  import hpi_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    last,
  output logic [N_REQ-1:0] grant
);

  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = PW'((int'(last) + i) % N_REQ);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hpi_txn_sequencer.sv
// Sequences arbitrated requests into HPI ADDRESS-write + DATA-access phases.
// Optional HPI_ADDR_CACHE_EN skips the address phase on a shadow-pointer hit.
module hpi_txn_sequencer
  import hpi_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int STROBE_CYC = 4,
  parameter int RECOV_CYC  = 2
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ-1:0]    req_we,
  input  logic [N_REQ*16-1:0] req_addr,
  input  logic [N_REQ*16-1:0] req_wdata,
  output logic [N_REQ-1:0]    ack,
  output logic [15:0]         rdata,
  output logic                busy,
  output logic [1:0]          hpi_address,
  output logic [15:0]         hpi_data_out,
  input  logic [15:0]         hpi_data_in,
  output logic                hpi_r,
  output logic                hpi_w,
  output logic                hpi_cs
);

  localparam int PW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int MAXC = max2(STROBE_CYC, RECOV_CYC);
  localparam int CW   = $clog2(MAXC);
  localparam logic [CW-1:0] S_LAST = CW'(STROBE_CYC - 1);
  localparam logic [CW-1:0] R_LAST = CW'(RECOV_CYC - 1);
  localparam logic [CW-1:0] RD_CAP = CW'(1);

  seq_state_e     state_q, state_d;
  logic [CW-1:0]  cnt_q;
  logic [PW-1:0]  gidx_q, gidx, rr_q;
  logic           we_q;
  logic [15:0]    addr_q, wdata_q, rdata_q, dout_q;
  hpi_reg_e       sel_q;
  logic [N_REQ-1:0] grant;
  logic           nxt_we, hit, d_we;
  logic [15:0]    nxt_addr, nxt_wdata, d_wdata;

  hpi_rr_arb #(
    .N_REQ(N_REQ),
    .PW   (PW)
  ) u_arb (
    .req  (req),
    .last (rr_q),
    .grant(grant)
  );

  always_comb begin
    gidx = '0;
    for (int i = 0; i < N_REQ; i++)
      if (grant[i]) gidx = PW'(i);
  end

  assign nxt_we    = req_we[gidx];
  assign nxt_addr  = req_addr[int'(gidx)*16 +: 16];
  assign nxt_wdata = req_wdata[int'(gidx)*16 +: 16];

`ifdef HPI_ADDR_CACHE_EN
  logic [15:0] shadow_q;
  logic        shadow_vld_q;

  assign hit = shadow_vld_q && (shadow_q == nxt_addr);

  // Chip pointer advances by one word after every DATA access.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      shadow_q     <= '0;
      shadow_vld_q <= 1'b0;
    end else if (state_q == DONE) begin
      shadow_q     <= addr_q + HPI_ADDR_STEP;
      shadow_vld_q <= 1'b1;
    end
  end
`else
  assign hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (|req) state_d = hit ? D_STB : A_STB;
      A_STB: if (cnt_q == S_LAST) state_d = A_REC;
      A_REC: if (cnt_q == R_LAST) state_d = D_STB;
      D_STB: if (cnt_q == S_LAST) state_d = D_REC;
      D_REC: if (cnt_q == R_LAST) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A cache hit enters D_STB straight from IDLE, before the payload is latched.
  assign d_we    = (state_q == IDLE) ? nxt_we    : we_q;
  assign d_wdata = (state_q == IDLE) ? nxt_wdata : wdata_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gidx_q  <= '0;
      rr_q    <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      sel_q   <= HPI_DATA;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q || state_q == IDLE)
        cnt_q <= '0;
      else
        cnt_q <= cnt_q + 1'b1;

      if (state_q == IDLE && |req) begin
        gidx_q  <= gidx;
        we_q    <= nxt_we;
        addr_q  <= nxt_addr;
        wdata_q <= nxt_wdata;
      end

      if (state_q == IDLE && state_d == A_STB) begin
        sel_q  <= HPI_ADDRESS;
        dout_q <= nxt_addr;
      end

      if (state_q != D_STB && state_d == D_STB) begin
        sel_q <= HPI_DATA;
        if (d_we) dout_q <= d_wdata;
      end

      // Bridge returns bus data two cycles after the read strobe.
      if (state_q == D_REC && !we_q && cnt_q == RD_CAP)
        rdata_q <= hpi_data_in;

      if (state_q == DONE)
        rr_q <= gidx_q;
    end
  end

  assign hpi_cs = !(state_q == A_STB || state_q == D_STB);
  assign hpi_w  = !(state_q == A_STB || (state_q == D_STB && we_q));
  assign hpi_r  = !(state_q == D_STB && !we_q);

  assign hpi_address  = sel_q;
  assign hpi_data_out = dout_q;
  assign rdata        = rdata_q;
  assign busy         = (state_q != IDLE);

  always_comb begin
    ack = '0;
    if (state_q == DONE) ack[gidx_q] = 1'b1;
  end

endmodule

// File: tb/tb_hpi_txn_sequencer.sv
// Self-checking bench for hpi_txn_sequencer with a registered HPI bridge
// and CY7C67200 memory model; bus phases and acks checked from scoreboards.
module tb_hpi_txn_sequencer;

  localparam int N = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req, req_we, ack;
  logic [N*16-1:0] req_addr, req_wdata;
  logic [15:0]     rdata, hpi_data_out;
  logic [15:0]     hpi_data_in = 16'h0;
  logic            busy, hpi_r, hpi_w, hpi_cs;
  logic [1:0]      hpi_address;

  always #5 clk = ~clk;

  hpi_txn_sequencer #(
    .N_REQ     (N),
    .STROBE_CYC(4),
    .RECOV_CYC (2)
  ) dut (
    .Clk         (clk),
    .Reset       (rst),
    .req         (req),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .ack         (ack),
    .rdata       (rdata),
    .busy        (busy),
    .hpi_address (hpi_address),
    .hpi_data_out(hpi_data_out),
    .hpi_data_in (hpi_data_in),
    .hpi_r       (hpi_r),
    .hpi_w       (hpi_w),
    .hpi_cs      (hpi_cs)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          idx;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rd;
    bit          skip;
  } vec_t;

  typedef struct {
    logic [1:0]  sel;
    logic [15:0] data;
    bit          wr;
    int          len;
  } ph_t;

  typedef struct {
    int          idx;
    bit          we;
    logic [15:0] rd;
  } tx_t;

  ph_t ph_q[$];
  tx_t tx_q[$];
  vec_t tbl[8];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bridge: strobes registered out, bus data registered back in.
  logic        cs_d = 1'b1, r_d = 1'b1, w_d = 1'b1;
  logic [1:0]  a_d = 2'b00;
  logic [15:0] o_d = 16'h0;
  logic [15:0] ptr = 16'h0;
  bit          in_data = 1'b0;
  logic [15:0] mem [int];

  always @(posedge clk) begin
    cs_d <= hpi_cs;
    r_d  <= hpi_r;
    w_d  <= hpi_w;
    a_d  <= hpi_address;
    o_d  <= hpi_data_out;
    if (!cs_d && !r_d && a_d == 2'b00)
      hpi_data_in <= mem.exists(int'(ptr)) ? mem[int'(ptr)] : 16'h0;
    if (!cs_d && !w_d && a_d == 2'b00)
      mem[int'(ptr)] = o_d;
    if (!cs_d && !w_d && a_d == 2'b10)
      ptr <= o_d;
    else if (cs_d && in_data)
      ptr <= ptr + 16'd2;
    if (!cs_d && a_d == 2'b00)
      in_data <= 1'b1;
    else if (cs_d)
      in_data <= 1'b0;
  end

  // Bus phase monitor.
  int  run = 0;
  bit  incons = 1'b0;
  ph_t cur;

  task automatic check_phase();
    ph_t e;
    if (ph_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL phase_unexpected: got sel=%h data=%h", cur.sel, cur.data);
    end else begin
      e = ph_q.pop_front();
      chk("phase_sel", 32'(cur.sel), 32'(e.sel));
      chk("phase_wr", 32'(cur.wr), 32'(e.wr));
      chk("phase_len", 32'(run), 32'(e.len));
      if (e.wr) chk("phase_data", 32'(cur.data), 32'(e.data));
      chk("phase_stable", 32'(incons), 32'd0);
    end
  endtask

  always @(negedge clk) begin
    checks++;
    if ((!hpi_r && !hpi_w) || ((!hpi_r || !hpi_w) && hpi_cs)) begin
      failures++;
      $display("FAIL strobe_excl: cs=%b r=%b w=%b", hpi_cs, hpi_r, hpi_w);
    end
    if (!hpi_cs) begin
      if (run == 0) begin
        cur.sel  = hpi_address;
        cur.data = hpi_data_out;
        cur.wr   = !hpi_w;
        incons   = 1'b0;
      end else if (hpi_address !== cur.sel || hpi_data_out !== cur.data ||
                   (!hpi_w) !== cur.wr) begin
        incons = 1'b1;
      end
      run++;
    end else if (run > 0) begin
      if (!rst) check_phase();
      run = 0;
    end
  end

  // Ack scoreboard.
  always @(negedge clk) begin
    if (ack !== '0) begin
      if (tx_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL ack_unexpected: got %b required none", ack);
      end else begin
        tx_t e;
        e = tx_q.pop_front();
        chk("ack_onehot", 32'($onehot(ack)), 32'd1);
        chk("ack_idx", 32'(ack), 32'(1) << e.idx);
        if (!e.we) chk("rdata", 32'(rdata), 32'(e.rd));
        chk("busy_at_ack", 32'(busy), 32'd1);
      end
    end
  end

  task automatic push_txn(vec_t v, bit skip);
    tx_q.push_back('{v.idx, v.we, v.rd});
    if (!skip) ph_q.push_back('{2'b10, v.addr, 1'b1, 4});
    ph_q.push_back('{2'b00, v.wdata, v.we, 4});
  endtask

  task automatic wait_ack(int idx, int exp_lat, bit mutate);
    int lat;
    bit got;
    lat = 0;
    got = 1'b0;
    for (int c = 0; c < 60 && !got; c++) begin
      @(posedge clk);
      #1;
      lat++;
      if (mutate && c == 2) begin
        req_addr[idx*16 +: 16]  = req_addr[idx*16 +: 16] ^ 16'hFFFF;
        req_wdata[idx*16 +: 16] = req_wdata[idx*16 +: 16] ^ 16'hFFFF;
      end
      if (ack[idx]) got = 1'b1;
    end
    req[idx] = 1'b0;
    chk("ack_seen", 32'(got), 32'd1);
    chk("latency", 32'(lat), 32'(exp_lat));
    @(posedge clk);
    #1;
    chk("ack_single", 32'(ack), 32'd0);
  endtask

  task automatic run_txn(vec_t v);
    bit skip;
`ifdef HPI_ADDR_CACHE_EN
    skip = v.skip;
`else
    skip = 1'b0;
`endif
    push_txn(v, skip);
    req_we[v.idx]             = v.we;
    req_addr[v.idx*16 +: 16]  = v.addr;
    req_wdata[v.idx*16 +: 16] = v.wdata;
    req[v.idx]                = 1'b1;
    wait_ack(v.idx, skip ? 7 : 13, 1'b1);
  endtask

  initial begin
    vec_t v;
    int   nack;

    mem[32'h0500] = 16'h1234;
    mem[32'h3000] = 16'h5A5A;
    mem[32'h2004] = 16'h4444;

    tbl[0] = '{0, 1'b1, 16'h1000, 16'hBEEF, 16'h0000, 1'b0};
    tbl[1] = '{1, 1'b0, 16'h0500, 16'h0000, 16'h1234, 1'b0};
    tbl[2] = '{0, 1'b1, 16'h2000, 16'h1111, 16'h0000, 1'b0};
    tbl[3] = '{1, 1'b1, 16'h2002, 16'h2222, 16'h0000, 1'b1};
    tbl[4] = '{0, 1'b0, 16'h3000, 16'h0000, 16'h5A5A, 1'b0};
    tbl[5] = '{1, 1'b0, 16'h2002, 16'h0000, 16'h2222, 1'b0};
    tbl[6] = '{0, 1'b0, 16'h2004, 16'h0000, 16'h4444, 1'b1};
    tbl[7] = '{1, 1'b1, 16'h5000, 16'h5555, 16'h0000, 1'b0};

    rst       = 1'b1;
    req       = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs", 32'(hpi_cs), 32'd1);
    chk("rst_r", 32'(hpi_r), 32'd1);
    chk("rst_w", 32'(hpi_w), 32'd1);
    chk("rst_addr", 32'(hpi_address), 32'd0);
    chk("rst_dout", 32'(hpi_data_out), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      run_txn(tbl[i]);
      repeat (2) @(posedge clk);
      #1;
    end

    // Both requesters held: last grantee was 1, so 0,1,0,1.
    req_we    = 2'b01;
    req_addr  = {16'h0500, 16'h4000};
    req_wdata = {16'h0000, 16'h0A0A};
    for (int k = 0; k < 4; k++) begin
      v = (k % 2 == 0) ? '{0, 1'b1, 16'h4000, 16'h0A0A, 16'h0000, 1'b0}
                       : '{1, 1'b0, 16'h0500, 16'h0000, 16'h1234, 1'b0};
      push_txn(v, 1'b0);
    end
    req  = 2'b11;
    nack = 0;
    for (int c = 0; c < 100 && nack < 4; c++) begin
      @(posedge clk);
      #1;
      if (ack !== '0) nack++;
      if (nack == 4) req = '0;
    end
    req = '0;
    chk("full_load_acks", 32'(nack), 32'd4);
    repeat (2) @(posedge clk);
    #1;

    // Reset in the first D_STB cycle drops the transaction.
    ph_q.push_back('{2'b10, 16'h6000, 1'b1, 4});
    req_we[0]          = 1'b1;
    req_addr[15:0]     = 16'h6000;
    req_wdata[15:0]    = 16'h7777;
    req[0]             = 1'b1;
    nack = 0;
    for (int c = 0; c < 40 && nack == 0; c++) begin
      @(posedge clk);
      #1;
      if (!hpi_cs && hpi_address == 2'b00) nack = 1;
    end
    chk("rst_reach_dstb", 32'(nack), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_cs", 32'(hpi_cs), 32'd1);
    chk("async_r", 32'(hpi_r), 32'd1);
    chk("async_w", 32'(hpi_w), 32'd1);
    chk("async_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_held_ack", 32'(ack), 32'd0);
    push_txn('{0, 1'b1, 16'h6000, 16'h7777, 16'h0000, 1'b0}, 1'b0);
    rst = 1'b0;
    wait_ack(0, 13, 1'b0);
    repeat (3) @(posedge clk);
    #1;

    chk("phase_q_empty", 32'(ph_q.size()), 32'd0);
    chk("tx_q_empty", 32'(tx_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
